// File: rtl/ysyx_041514_lsu_ctrl.sv
// Single-outstanding load/store sequencer for the MEM stage (64-bit data port).
// Optional misaligned-access trap: define YSYX_041514_LSU_MISALIGN_CHECK_EN.
//
// state  | meaning
// IDLE   | waiting for ls_valid_i, latches the access
// REQ    | memory request presented until ready
// WAIT   | waiting for the memory response
// DONE   | one-cycle completion pulse, load data valid
module ysyx_041514_lsu_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        ls_valid_i,
    input  logic        ls_type_i,
    input  logic        ls_signed_i,
    input  logic [3:0]  ls_size_i,
    input  logic [63:0] ls_addr_i,
    input  logic [63:0] ls_wdata_i,
    output logic        stall_o,
    output logic        ls_done_o,
    output logic [63:0] ls_rdata_o,
    output logic        misalign_o,
    output logic        mem_req_valid_o,
    input  logic        mem_req_ready_i,
    output logic [63:0] mem_addr_o,
    output logic        mem_wen_o,
    output logic [63:0] mem_wdata_o,
    output logic [7:0]  mem_wstrb_o,
    input  logic        mem_rsp_valid_i,
    input  logic [63:0] mem_rdata_i
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_type;
    logic        r_signed;
    logic [1:0]  r_size;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;
    logic [63:0] r_rdata;
    logic        r_misalign;

    logic [1:0]  w_size_in;
    logic        w_mis_in;
    logic [2:0]  w_off;
    logic [7:0]  w_mask;
    logic [63:0] w_shifted;
    logic [63:0] w_load;
    logic        w_req;
    logic        w_done;

    // Size code is log2(bytes); highest set bit wins, all-zero means 8 bytes.
    always_comb begin
        w_size_in = 2'd0;
        if (ls_size_i[3] || (ls_size_i == 4'b0000)) w_size_in = 2'd3;
        else if (ls_size_i[2])                      w_size_in = 2'd2;
        else if (ls_size_i[1])                      w_size_in = 2'd1;
    end

`ifdef YSYX_041514_LSU_MISALIGN_CHECK_EN
    always_comb begin
        w_mis_in = 1'b0;
        case (w_size_in)
            2'd0:    w_mis_in = 1'b0;
            2'd1:    w_mis_in = ls_addr_i[0];
            2'd2:    w_mis_in = |ls_addr_i[1:0];
            default: w_mis_in = |ls_addr_i[2:0];
        endcase
    end
`else
    assign w_mis_in = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (ls_valid_i) w_next = w_mis_in ? S_DONE : S_REQ;
            S_REQ:  if (mem_req_ready_i) w_next = S_WAIT;
            S_WAIT: if (mem_rsp_valid_i) w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_type     <= 1'b0;
            r_signed   <= 1'b0;
            r_size     <= 2'd0;
            r_addr     <= 64'd0;
            r_wdata    <= 64'd0;
            r_rdata    <= 64'd0;
            r_misalign <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    r_rdata    <= 64'd0;
                    r_misalign <= 1'b0;
                    if (ls_valid_i) begin
                        r_type     <= ls_type_i;
                        r_signed   <= ls_signed_i;
                        r_size     <= w_size_in;
                        r_addr     <= ls_addr_i;
                        r_wdata    <= ls_wdata_i;
                        r_misalign <= w_mis_in;
                    end
                end
                S_WAIT: if (mem_rsp_valid_i) r_rdata <= r_type ? 64'd0 : w_load;
                default: ;
            endcase
        end
    end

    assign w_off = r_addr[2:0];

    always_comb begin
        w_mask = 8'hFF;
        case (r_size)
            2'd0:    w_mask = 8'h01;
            2'd1:    w_mask = 8'h03;
            2'd2:    w_mask = 8'h0F;
            default: w_mask = 8'hFF;
        endcase
    end

    assign w_shifted = mem_rdata_i >> {w_off, 3'b000};

    always_comb begin
        w_load = w_shifted;
        case (r_size)
            2'd0:    w_load = {{56{r_signed & w_shifted[7]}},  w_shifted[7:0]};
            2'd1:    w_load = {{48{r_signed & w_shifted[15]}}, w_shifted[15:0]};
            2'd2:    w_load = {{32{r_signed & w_shifted[31]}}, w_shifted[31:0]};
            default: w_load = w_shifted;
        endcase
    end

    assign w_req  = (r_state == S_REQ);
    assign w_done = (r_state == S_DONE);

    // Memory-side outputs come only from latched state so they hold still in REQ.
    assign mem_req_valid_o = w_req;
    assign mem_addr_o      = w_req ? {r_addr[63:3], 3'b000} : 64'd0;
    assign mem_wen_o       = w_req & r_type;
    assign mem_wdata_o     = w_req ? (r_wdata << {w_off, 3'b000}) : 64'd0;
    assign mem_wstrb_o     = w_req ? (w_mask << w_off) : 8'd0;

    assign ls_done_o  = w_done;
    assign ls_rdata_o = w_done ? r_rdata : 64'd0;
    assign misalign_o = w_done & r_misalign;

    always_comb begin
        stall_o = 1'b0;
        case (r_state)
            S_IDLE:  stall_o = ls_valid_i;
            S_REQ:   stall_o = 1'b1;
            S_WAIT:  stall_o = 1'b1;
            default: stall_o = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_ysyx_041514_lsu_ctrl.sv
// Directed bench for ysyx_041514_lsu_ctrl with a queue of expected completions.
// Misaligned-access expectations follow YSYX_041514_LSU_MISALIGN_CHECK_EN.
module tb_ysyx_041514_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ls_valid_i;
    logic        ls_type_i;
    logic        ls_signed_i;
    logic [3:0]  ls_size_i;
    logic [63:0] ls_addr_i;
    logic [63:0] ls_wdata_i;
    logic        stall_o;
    logic        ls_done_o;
    logic [63:0] ls_rdata_o;
    logic        misalign_o;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i;
    logic [63:0] mem_addr_o;
    logic        mem_wen_o;
    logic [63:0] mem_wdata_o;
    logic [7:0]  mem_wstrb_o;
    logic        mem_rsp_valid_i;
    logic [63:0] mem_rdata_i;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] rdata;
        logic        mis;
        logic [63:0] addr;
        logic        wen;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        int          lat;
    } exp_t;

    exp_t exp_q[$];

    ysyx_041514_lsu_ctrl dut (
        .clk(clk), .rst(rst),
        .ls_valid_i(ls_valid_i), .ls_type_i(ls_type_i), .ls_signed_i(ls_signed_i),
        .ls_size_i(ls_size_i), .ls_addr_i(ls_addr_i), .ls_wdata_i(ls_wdata_i),
        .stall_o(stall_o), .ls_done_o(ls_done_o), .ls_rdata_o(ls_rdata_o),
        .misalign_o(misalign_o), .mem_req_valid_o(mem_req_valid_o),
        .mem_req_ready_i(mem_req_ready_i), .mem_addr_o(mem_addr_o),
        .mem_wen_o(mem_wen_o), .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
        .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_done"},   ls_done_o, 1'b0);
        chk({tag, "_rdata"},  ls_rdata_o, 64'd0);
        chk({tag, "_mis"},    misalign_o, 1'b0);
        chk({tag, "_reqv"},   mem_req_valid_o, 1'b0);
        chk({tag, "_addr"},   mem_addr_o, 64'd0);
        chk({tag, "_wen"},    mem_wen_o, 1'b0);
        chk({tag, "_wdata"},  mem_wdata_o, 64'd0);
        chk({tag, "_wstrb"},  mem_wstrb_o, 8'd0);
        chk({tag, "_stall"},  stall_o, 1'b0);
    endtask

    // Drives one access, plays the memory side and checks the completion.
    task automatic run_access(input string tag, input logic typ, input logic sgn,
                              input logic [3:0] size, input logic [63:0] addr,
                              input logic [63:0] wdata, input logic [63:0] memdata,
                              input int delay, input logic [63:0] e_rdata, input logic e_mis,
                              input logic [7:0] e_wstrb, input logic [63:0] e_wdata);
        exp_t e;
        int   cyc;
        int   req_cycles;
        bit   hs;
        bit   done;
        e.rdata = e_rdata;
        e.mis   = e_mis;
        e.addr  = {addr[63:3], 3'b000};
        e.wen   = typ;
        e.wdata = e_wdata;
        e.wstrb = e_wstrb;
        e.lat   = e_mis ? 1 : 3 + delay;
        exp_q.push_back(e);

        ls_valid_i  = 1'b1;
        ls_type_i   = typ;
        ls_signed_i = sgn;
        ls_size_i   = size;
        ls_addr_i   = addr;
        ls_wdata_i  = wdata;
        #1;
        chk({tag, "_stall_idle"}, stall_o, 1'b1);
        step();
        cyc = 1; req_cycles = 0; hs = 0; done = 0;
        while (!done && cyc < 40) begin
            if (ls_done_o) begin
                e = exp_q.pop_front();
                chk({tag, "_rdata"},  ls_rdata_o, e.rdata);
                chk({tag, "_mis"},    misalign_o, e.mis);
                chk({tag, "_lat"},    cyc, e.lat);
                chk({tag, "_stall_done"}, stall_o, 1'b0);
                chk({tag, "_reqs"},   req_cycles, e.mis ? 0 : delay + 1);
                done = 1;
                ls_valid_i      = 1'b0;
                mem_req_ready_i = 1'b0;
                mem_rsp_valid_i = 1'b0;
                mem_rdata_i     = 64'd0;
            end else begin
                chk({tag, "_stall"}, stall_o, 1'b1);
                if (mem_req_valid_o) begin
                    chk({tag, "_addr"}, mem_addr_o, exp_q[0].addr);
                    chk({tag, "_wen"},  mem_wen_o,  exp_q[0].wen);
                    if (typ) begin
                        chk({tag, "_wdata"}, mem_wdata_o, exp_q[0].wdata);
                        chk({tag, "_wstrb"}, mem_wstrb_o, exp_q[0].wstrb);
                    end
                    req_cycles++;
                    mem_req_ready_i = (req_cycles > delay);
                    mem_rsp_valid_i = !mem_req_ready_i;
                    mem_rdata_i     = 64'hBAD0_BAD0_BAD0_BAD0;
                    hs = mem_req_ready_i;
                end else begin
                    chk({tag, "_addr_off"}, mem_addr_o, 64'd0);
                    chk({tag, "_wstrb_off"}, mem_wstrb_o, 8'd0);
                    mem_req_ready_i = 1'b0;
                    mem_rsp_valid_i = hs;
                    mem_rdata_i     = hs ? memdata : 64'd0;
                end
                cyc++;
            end
            step();
        end
        chk({tag, "_completed"}, done, 1'b1);
        chk_idle_outputs({tag, "_after"});
    endtask

    initial begin
        rst = 1'b1;
        ls_valid_i = 0; ls_type_i = 0; ls_signed_i = 0; ls_size_i = 0;
        ls_addr_i = 0; ls_wdata_i = 0;
        mem_req_ready_i = 0; mem_rsp_valid_i = 0; mem_rdata_i = 0;
        step();
        step();
        chk_idle_outputs("reset");
        rst = 1'b0;
        step();
        chk_idle_outputs("post_reset");

        run_access("lb", 1'b0, 1'b1, 4'b0001, 64'h8000_0003, 64'd0,
                   64'h0000_0000_8000_0000, 0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 8'h00, 64'd0);
        run_access("lwu", 1'b0, 1'b0, 4'b0100, 64'h8000_0004, 64'd0,
                   64'hDEAD_BEEF_0000_0000, 0, 64'h0000_0000_DEAD_BEEF, 1'b0, 8'h00, 64'd0);
        run_access("sh", 1'b1, 1'b0, 4'b0010, 64'h8000_0006, 64'h1234,
                   64'd0, 0, 64'd0, 1'b0, 8'hC0, 64'h1234_0000_0000_0000);
        run_access("sd_wait", 1'b1, 1'b0, 4'b1000, 64'h8000_0010, 64'h0123_4567_89AB_CDEF,
                   64'd0, 3, 64'd0, 1'b0, 8'hFF, 64'h0123_4567_89AB_CDEF);
        run_access("lh", 1'b0, 1'b1, 4'b0010, 64'h8000_0002, 64'd0,
                   64'h0000_0000_8001_0000, 1, 64'hFFFF_FFFF_FFFF_8001, 1'b0, 8'h00, 64'd0);
        run_access("ld_size0", 1'b0, 1'b1, 4'b0000, 64'h8000_0008, 64'd0,
                   64'hF000_0000_0000_0001, 0, 64'hF000_0000_0000_0001, 1'b0, 8'h00, 64'd0);
        run_access("lw_multi", 1'b0, 1'b1, 4'b0110, 64'h8000_0000, 64'd0,
                   64'h0000_0000_9000_0001, 2, 64'hFFFF_FFFF_9000_0001, 1'b0, 8'h00, 64'd0);
`ifdef YSYX_041514_LSU_MISALIGN_CHECK_EN
        run_access("lw_mis", 1'b0, 1'b1, 4'b0100, 64'h8000_0002, 64'd0,
                   64'h0000_1122_3344_0000, 0, 64'd0, 1'b1, 8'h00, 64'd0);
        run_access("sw_mis", 1'b1, 1'b0, 4'b0100, 64'h8000_0006, 64'hAABB_CCDD,
                   64'd0, 0, 64'd0, 1'b1, 8'h00, 64'd0);
`else
        run_access("lw_mis", 1'b0, 1'b1, 4'b0100, 64'h8000_0002, 64'd0,
                   64'h0000_1122_3344_0000, 0, 64'h0000_0000_1122_3344, 1'b0, 8'h00, 64'd0);
        run_access("sw_mis", 1'b1, 1'b0, 4'b0100, 64'h8000_0006, 64'hAABB_CCDD,
                   64'd0, 0, 64'd0, 1'b0, 8'hC0, 64'hCCDD_0000_0000_0000);
`endif

        // Reset while waiting for a load response; the late response must be dropped.
        ls_valid_i = 1'b1; ls_type_i = 1'b0; ls_signed_i = 1'b0;
        ls_size_i = 4'b0100; ls_addr_i = 64'h8000_0000; ls_wdata_i = 64'd0;
        step();
        chk("rstw_in_req", mem_req_valid_o, 1'b1);
        mem_req_ready_i = 1'b1;
        step();
        mem_req_ready_i = 1'b0;
        ls_valid_i = 1'b0;
        chk("rstw_in_wait", stall_o, 1'b1);
        rst = 1'b1;
        #1;
        chk_idle_outputs("rstw_asserted");
        step();
        rst = 1'b0;
        mem_rsp_valid_i = 1'b1;
        mem_rdata_i = 64'h5555_5555_5555_5555;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_idle_outputs("rstw_late_rsp");
        end
        mem_rsp_valid_i = 1'b0;
        mem_rdata_i = 64'd0;

        chk("sb_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
